// File: rtl/inst_decode_buffer.sv
// Instruction decode buffer: a DEPTH-entry circular queue of fetched
// {instruction, PC} pairs, with the head entry presented fully decoded
// into R/I/J fields for the register-read stage.
module inst_decode_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  instruction,
    input  logic [XLEN-1:0]              p_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [5:0]                   opcode,
    output logic [4:0]                   rs,
    output logic [4:0]                   rt,
    output logic [4:0]                   rd,
    output logic [4:0]                   shamt,
    output logic [5:0]                   funct,
    output logic [15:0]                  immediate,
    output logic [XLEN-1:0]              imm_ext,
    output logic [25:0]                  address,
    output logic [1:0]                   itype,
    output logic [XLEN-1:0]              pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IT_R    = 2'd0,
        IT_I    = 2'd1,
        IT_J    = 2'd2,
        IT_NONE = 2'd3
    } itype_e;

    logic [31:0]      mem_instr [DEPTH];
    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [31:0]      head_instr;
    logic [5:0]       head_op;
    itype_e           cls;

    // Handshake qualifiers; in_ready never looks at out_ready, so a full
    // queue refuses a push even when the head is being consumed.
    assign in_ready  = rst_n && !flush && (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head_instr = mem_instr[rd_ptr];
    assign head_op    = head_instr[31:26];
    assign itype      = cls;

    // Queue storage: written on an accepted push only.
    // NOTE: the entry array has no reset; validity is tracked solely by
    // count, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= instruction;
            mem_pc[wr_ptr]    <= p_count;
        end
    end

    // Pointer and occupancy update; reset wins over flush, flush over handshakes.
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head decode: classify the opcode and drive only that class's fields.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cls       = IT_NONE;
        opcode    = '0;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        shamt     = '0;
        funct     = '0;
        immediate = '0;
        imm_ext   = '0;
        address   = '0;
        pc_out    = '0;
        if (out_valid) begin
            opcode = head_op;
            pc_out = mem_pc[rd_ptr];
            if (head_op == 6'h00 || head_op == 6'h3E) begin
                cls   = IT_R;
                rs    = head_instr[25:21];
                rt    = head_instr[20:16];
                rd    = head_instr[15:11];
                shamt = head_instr[10:6];
                funct = head_instr[5:0];
            end else if (head_op == 6'h02 || head_op == 6'h03) begin
                cls     = IT_J;
                address = head_instr[25:0];
            end else begin
                cls       = IT_I;
                rs        = head_instr[25:21];
                rt        = head_instr[20:16];
                immediate = head_instr[15:0];
                // Logical immediates (andi/ori/xori) are zero-extended.
                if (head_op == 6'h0C || head_op == 6'h0D || head_op == 6'h0E)
                    imm_ext = {{(XLEN-16){1'b0}}, head_instr[15:0]};
                else
                    imm_ext = {{(XLEN-16){head_instr[15]}}, head_instr[15:0]};
            end
        end
    end

endmodule

// File: tb/tb_inst_decode_buffer.sv
// Self-checking bench for inst_decode_buffer: a decode vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// queue-based reference model.
module tb_inst_decode_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [XLEN-1:0]   p_count;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       immediate;
    logic [XLEN-1:0]   imm_ext;
    logic [25:0]       address;
    logic [1:0]        itype;
    logic [XLEN-1:0]   pc_out;
    logic [2:0]        count;

    inst_decode_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .p_count(p_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .immediate(immediate), .imm_ext(imm_ext),
        .address(address), .itype(itype), .pc_out(pc_out), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  itype;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] imm_ext;
        logic [25:0] addr;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    vec_t   vecs [10];
    entry_t model_q [$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode written directly from the instruction-format rules.
    function automatic vec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        vec_t       r;
        logic [5:0] op;
        op = w[31:26];
        r = '{instr: w, pc: pc, itype: 2'd1, rs: 5'd0, rt: 5'd0, rd: 5'd0, shamt: 5'd0,
              funct: 6'd0, imm: 16'd0, imm_ext: 32'd0, addr: 26'd0};
        if (op == 6'h00 || op == 6'h3E) begin
            r.itype = 2'd0;
            r.rs = w[25:21]; r.rt = w[20:16]; r.rd = w[15:11];
            r.shamt = w[10:6]; r.funct = w[5:0];
        end else if (op == 6'h02 || op == 6'h03) begin
            r.itype = 2'd2;
            r.addr  = w[25:0];
        end else begin
            r.rs = w[25:21]; r.rt = w[20:16]; r.imm = w[15:0];
            if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
                r.imm_ext = 32'(w[15:0]);
            else
                r.imm_ext = 32'(signed'(w[15:0]));
        end
        return r;
    endfunction

    task automatic check_head(input string tag, input vec_t v);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".itype"},     64'(itype),     64'(v.itype));
        check({tag, ".opcode"},    64'(opcode),    64'(v.instr[31:26]));
        check({tag, ".rs"},        64'(rs),        64'(v.rs));
        check({tag, ".rt"},        64'(rt),        64'(v.rt));
        check({tag, ".rd"},        64'(rd),        64'(v.rd));
        check({tag, ".shamt"},     64'(shamt),     64'(v.shamt));
        check({tag, ".funct"},     64'(funct),     64'(v.funct));
        check({tag, ".immediate"}, 64'(immediate), 64'(v.imm));
        check({tag, ".imm_ext"},   64'(imm_ext),   64'(v.imm_ext));
        check({tag, ".address"},   64'(address),   64'(v.addr));
        check({tag, ".pc_out"},    64'(pc_out),    64'(v.pc));
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".itype"},     64'(itype),     64'd3);
        check({tag, ".fields"},
              64'({opcode, rs, rt, rd, shamt, funct, immediate, address}), 64'd0);
        check({tag, ".imm_ext"},   64'(imm_ext),   64'd0);
        check({tag, ".pc_out"},    64'(pc_out),    64'd0);
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] pc);
        instruction = w;
        p_count     = pc;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        entry_t e_full [4];
        entry_t ent;
        // Decode vectors with hand-derived expectations.
        vecs[0] = '{32'h012A4020, 32'h0040_0000, 2'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 32'h0, 26'h0};
        vecs[1] = '{32'h2128FFFF, 32'h0040_0004, 2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 32'hFFFF_FFFF, 26'h0};
        vecs[2] = '{32'h3528FFFF, 32'h0040_0008, 2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 32'h0000_FFFF, 26'h0};
        vecs[3] = '{32'h0C100010, 32'h0040_000C, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0, 26'h0100010};
        vecs[4] = '{{6'h3E, 5'd3, 5'd4, 5'd5, 5'd6, 6'h2A}, 32'h0040_0010, 2'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'h2A, 16'h0, 32'h0, 26'h0};
        vecs[5] = '{{6'h23, 5'd29, 5'd2, 16'h0010}, 32'h0040_0014, 2'd1, 5'd29, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0010, 32'h0000_0010, 26'h0};
        vecs[6] = '{{6'h0C, 5'd1, 5'd2, 16'h8000}, 32'h0040_0018, 2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h8000, 32'h0000_8000, 26'h0};
        vecs[7] = '{{6'h04, 5'd3, 5'd4, 16'h8001}, 32'h0040_001C, 2'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h8001, 32'hFFFF_8001, 26'h0};
        vecs[8] = '{{6'h02, 26'h3FF_FFFF}, 32'h0040_0020, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0, 26'h3FF_FFFF};
        vecs[9] = '{{6'h0E, 5'd7, 5'd8, 16'hFFFF}, 32'h0040_0024, 2'd1, 5'd7, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 32'h0000_FFFF, 26'h0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0; p_count = '0;

        // Reset held for two edges.
        tick();
        tick();
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.count", 64'(count), 64'd0);
        check_empty("rst");
        rst_n = 1'b1;
        #1;
        check("rel.in_ready", 64'(in_ready), 64'd1);

        // Table: push one word, check its decode one cycle later, pop it.
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].instr, vecs[i].pc);
            check($sformatf("vec%0d.count", i), 64'(count), 64'd1);
            check_head($sformatf("vec%0d", i), vecs[i]);
            pop();
            check($sformatf("vec%0d.drained", i), 64'(count), 64'd0);
        end

        // Full boundary and FIFO order across pointer wrap.
        for (int k = 0; k < 4; k++) begin
            e_full[k] = '{instr: {6'h08, 5'(k), 5'(k + 1), 16'(16'h1000 + k)}, pc: 32'h0050_0000 + 32'(4 * k)};
            push(e_full[k].instr, e_full[k].pc);
        end
        check("full.count", 64'(count), 64'd4);
        check("full.in_ready", 64'(in_ready), 64'd0);
        instruction = 32'hDEAD_BEEF; p_count = 32'h0BAD_0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("full.no_fifth", 64'(count), 64'd4);
        check_head("full.head0", ref_decode(e_full[0].instr, e_full[0].pc));
        pop();
        check("full.pop1.count", 64'(count), 64'd3);
        for (int k = 1; k < 4; k++) begin
            check_head($sformatf("drain%0d", k), ref_decode(e_full[k].instr, e_full[k].pc));
            pop();
        end
        check("drain.count", 64'(count), 64'd0);
        check_empty("drain");

        // Simultaneous push/pop at count 2, then flush with a push pending.
        push(32'h2001_0001, 32'h0060_0000);
        push(32'h2002_0002, 32'h0060_0004);
        check("pp.count_before", 64'(count), 64'd2);
        instruction = 32'h2003_0003; p_count = 32'h0060_0008;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp.count_after", 64'(count), 64'd2);
        check_head("pp.head", ref_decode(32'h2002_0002, 32'h0060_0004));
        flush = 1'b1; in_valid = 1'b1;
        instruction = 32'h2004_0004; p_count = 32'h0060_000C;
        #1;
        check("flush.in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.count", 64'(count), 64'd0);
        check_empty("flush");
        push(32'h2005_0005, 32'h0060_0010);
        check("flush.after_count", 64'(count), 64'd1);
        check_head("flush.after", ref_decode(32'h2005_0005, 32'h0060_0010));
        pop();

        // Reset in the middle of a stream.
        for (int k = 0; k < 3; k++) push(32'h2400_0000 + 32'(k), 32'h0070_0000 + 32'(4 * k));
        check("mrst.count_before", 64'(count), 64'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst.count", 64'(count), 64'd0);
        check_empty("mrst");
        push(32'h0128_4822, 32'h0070_0100);
        check_head("mrst.push", ref_decode(32'h0128_4822, 32'h0070_0100));
        pop();

        // Randomized traffic against the queue model.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic iv, ordy, fl, exp_ready, do_push, do_pop;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) == 0);
            fl   = ($urandom_range(0, 24) == 0);
            instruction = $urandom;
            p_count     = $urandom;
            in_valid = iv; out_ready = ordy; flush = fl;
            #1;
            exp_ready = !fl && (model_q.size() < DEPTH);
            check("rnd.in_ready", 64'(in_ready), 64'(exp_ready));
            do_push = iv && exp_ready;
            do_pop  = (model_q.size() > 0) && ordy;
            ent = '{instr: instruction, pc: p_count};
            tick();
            if (fl) model_q.delete();
            else begin
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back(ent);
            end
            check("rnd.count", 64'(count), 64'(model_q.size()));
            if (model_q.size() > 0) check_head("rnd", ref_decode(model_q[0].instr, model_q[0].pc));
            else                    check_empty("rnd");
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
